// File: rtl/ls_unit.sv
// rtl/ls_unit.sv - load/store execution unit driving a shared byte-wide memory port
module ls_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        LSworkEn,
    input  logic [31:0] operandO,
    input  logic [31:0] operandT,
    input  logic [31:0] imm,
    input  logic [5:0]  wrtTag,
    input  logic [4:0]  wrtName,
    input  logic [3:0]  opCode,
    output logic        LSreadEn,
    output logic        enLSwrt,
    output logic [5:0]  LStag,
    output logic [31:0] LSdata,
    output logic [4:0]  LSname,
    output logic        memReq,
    input  logic        memGrant,
    output logic [31:0] memAddr,
    output logic        memWr,
    output logic [7:0]  memDout,
    input  logic [7:0]  memDin
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [5:0]  TAG_FREE  = 6'd0;
    localparam logic [4:0]  NAME_FREE = 5'd0;
    localparam logic [31:0] DATA_FREE = 32'd0;

    typedef enum logic [2:0] {IDLE, REQ, XFER, LAST, DONE} state_t;

    state_t      state, state_n;
    logic [31:0] addr, addr_n;
    logic [31:0] data, data_n;
    logic [31:0] result, result_n;
    logic [3:0]  op, op_n;
    logic [5:0]  tag, tag_n;
    logic [4:0]  name, name_n;
    logic [1:0]  k, k_n;
    logic [1:0]  last_k, last_k_n;

    logic        LSreadEn_n, enLSwrt_n, memReq_n, memWr_n;
    logic [5:0]  LStag_n;
    logic [4:0]  LSname_n;
    logic [31:0] LSdata_n, memAddr_n;
    logic [7:0]  memDout_n;

    logic        op_valid, is_store, accept;
    logic [1:0]  issue_last_k, k_inc, k_dec;
    logic [7:0]  next_byte;
    logic [31:0] full;

    always_comb begin
        op_valid = (opCode >= OP_LB) && (opCode <= OP_SW);
        is_store = (op >= OP_SB);
        accept   = LSreadEn && LSworkEn && op_valid;
        k_inc    = k + 2'd1;
        k_dec    = k - 2'd1;
        next_byte = 8'(data >> {k_inc, 3'b000});
        // Final byte merges straight into the CDB value so the write lands in DONE.
        full     = result | ({24'd0, memDin} << {last_k, 3'b000});
        case (opCode)
            OP_LH, OP_LHU, OP_SH: issue_last_k = 2'd1;
            OP_LW, OP_SW:         issue_last_k = 2'd3;
            default:              issue_last_k = 2'd0;
        endcase
    end

    always_comb begin
        state_n    = state;
        addr_n     = addr;
        data_n     = data;
        result_n   = result;
        op_n       = op;
        tag_n      = tag;
        name_n     = name;
        k_n        = k;
        last_k_n   = last_k;
        LSreadEn_n = LSreadEn;
        enLSwrt_n  = 1'b0;
        LStag_n    = LStag;
        LSdata_n   = LSdata;
        LSname_n   = LSname;
        memReq_n   = memReq;
        memAddr_n  = memAddr;
        memWr_n    = memWr;
        memDout_n  = memDout;
        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (accept) begin
                    state_n    = REQ;
                    addr_n     = operandO + imm;
                    data_n     = operandT;
                    op_n       = opCode;
                    tag_n      = wrtTag;
                    name_n     = wrtName;
                    last_k_n   = issue_last_k;
                    result_n   = '0;
                    LSreadEn_n = 1'b0;
                    memReq_n   = 1'b1;
                    memWr_n    = 1'b0;
                end
            end
            REQ: begin
                if (memGrant) begin
                    state_n   = XFER;
                    k_n       = 2'd0;
                    memAddr_n = addr;
                    memWr_n   = is_store;
                    memDout_n = data[7:0];
                end
            end
            XFER: begin
                // memDin carries the byte addressed in the previous cycle.
                if (!is_store && (k != 2'd0))
                    result_n = result | ({24'd0, memDin} << {k_dec, 3'b000});
                if (k == last_k) begin
                    memWr_n = 1'b0;
                    if (is_store) begin
                        state_n    = DONE;
                        memReq_n   = 1'b0;
                        LSreadEn_n = 1'b1;
                    end else begin
                        state_n = LAST;
                    end
                end else begin
                    k_n       = k_inc;
                    memAddr_n = addr + {30'd0, k_inc};
                    memDout_n = next_byte;
                end
            end
            LAST: begin
                state_n    = DONE;
                memReq_n   = 1'b0;
                LSreadEn_n = 1'b1;
                enLSwrt_n  = 1'b1;
                LStag_n    = tag;
                LSname_n   = name;
                case (op)
                    OP_LB:   LSdata_n = {{24{full[7]}}, full[7:0]};
                    OP_LH:   LSdata_n = {{16{full[15]}}, full[15:0]};
                    OP_LBU:  LSdata_n = {24'd0, full[7:0]};
                    OP_LHU:  LSdata_n = {16'd0, full[15:0]};
                    default: LSdata_n = full;
                endcase
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            addr     <= '0;
            data     <= '0;
            result   <= '0;
            op       <= '0;
            tag      <= '0;
            name     <= '0;
            k        <= '0;
            last_k   <= '0;
            LSreadEn <= 1'b1;
            enLSwrt  <= 1'b0;
            LStag    <= TAG_FREE;
            LSdata   <= DATA_FREE;
            LSname   <= NAME_FREE;
            memReq   <= 1'b0;
            memAddr  <= '0;
            memWr    <= 1'b0;
            memDout  <= '0;
        end else begin
            state    <= state_n;
            addr     <= addr_n;
            data     <= data_n;
            result   <= result_n;
            op       <= op_n;
            tag      <= tag_n;
            name     <= name_n;
            k        <= k_n;
            last_k   <= last_k_n;
            LSreadEn <= LSreadEn_n;
            enLSwrt  <= enLSwrt_n;
            LStag    <= LStag_n;
            LSdata   <= LSdata_n;
            LSname   <= LSname_n;
            memReq   <= memReq_n;
            memAddr  <= memAddr_n;
            memWr    <= memWr_n;
            memDout  <= memDout_n;
        end
    end
endmodule
